// File: rtl/gf2_mv_operand_loader.sv
// Serial-to-parallel operand loader for the GF(2) matrix-vector multiplier.
// Assembles an NxN bit matrix plus an N-bit vector and holds them until accepted.
module gf2_mv_operand_loader #(
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_bit,
  input  logic           in_keep,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*N-1:0] a_flat,
  output logic [N-1:0]   v,
  output logic           mat_ok
);
  localparam int CW = $clog2(N*N+1);

  typedef enum logic [1:0] {IDLE, MAT, VEC, OUT} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [N*N-1:0]  a_q;
  logic [N-1:0]    v_q;
  logic            mat_ok_q;

  assign in_ready  = (state_q != OUT);
  assign out_valid = (state_q == OUT);
  assign a_flat    = a_q;
  assign v         = v_q;
  assign mat_ok    = mat_ok_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      v_q      <= '0;
      mat_ok_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          cnt_q <= CW'(1);
          // A keep request is only honoured once a full matrix is stored.
          if (in_keep && mat_ok_q) begin
            v_q[0]  <= in_bit;
            state_q <= VEC;
          end else begin
            a_q[0]   <= in_bit;
            mat_ok_q <= 1'b0;
            state_q  <= MAT;
          end
        end
        MAT: if (in_valid) begin
          for (int k = 0; k < N*N; k++)
            if (cnt_q == CW'(k)) a_q[k] <= in_bit;
          if (cnt_q == CW'(N*N-1)) begin
            mat_ok_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= VEC;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        VEC: if (in_valid) begin
          for (int i = 0; i < N; i++)
            if (cnt_q == CW'(i)) v_q[i] <= in_bit;
          if (cnt_q == CW'(N-1)) begin
            cnt_q   <= '0;
            state_q <= OUT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        OUT: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gf2_mv_operand_loader.sv
// Directed bench for gf2_mv_operand_loader at N=3.
module tb_gf2_mv_operand_loader;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_bit = 1'b0;
  logic           in_keep = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [N*N-1:0] a_flat;
  logic [N-1:0]   v;
  logic           mat_ok;

  int errors = 0;
  int checks = 0;

  gf2_mv_operand_loader #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_bit(in_bit), .in_keep(in_keep), .out_valid(out_valid),
    .out_ready(out_ready), .a_flat(a_flat), .v(v), .mat_ok(mat_ok)
  );

  always #5 clk = ~clk;

  // Present one beat, wait (bounded) for acceptance, then drop in_valid.
  task automatic beat(input logic b, input logic k, input int gap);
    int t;
    for (int g = 0; g < gap; g++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_bit = b; in_keep = k;
    t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (!in_ready) begin errors++; $display("FAIL beat_timeout in_ready=%b required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_keep = 1'b0;
  endtask

  // bits[k] is beat k: matrix beats 0..8, then vector beats 9..11.
  task automatic frame(input logic [N*N+N-1:0] bits, input logic k0, input logic gapped);
    for (int k = 0; k < N*N+N; k++)
      beat(bits[k], (k == 0) ? k0 : 1'b0, gapped ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic release_out();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL release out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || a_flat !== 9'b0 || v !== 3'b0 || mat_ok !== 1'b0) begin
      errors++;
      $display("FAIL reset ov=%b ir=%b a=%b v=%b mo=%b required 0 1 0 0 0", out_valid, in_ready, a_flat, v, mat_ok);
    end
  endtask

  task automatic test_full_frame(input logic gapped);
    frame({3'b101, 9'b100010001}, 1'b0, gapped);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_valid ov=%b ir=%b required 1/0", out_valid, in_ready);
    end
    checks++;
    if (a_flat !== 9'b100010001 || v !== 3'b101 || mat_ok !== 1'b1) begin
      errors++; $display("FAIL full_data a=%b v=%b mo=%b required 100010001 101 1", a_flat, v, mat_ok);
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_bit = c[0]; out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || a_flat !== 9'b100010001 || v !== 3'b101) begin
        errors++;
        $display("FAIL backpressure c=%0d ir=%b ov=%b a=%b v=%b required 0 1 100010001 101", c, in_ready, out_valid, a_flat, v);
      end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || a_flat !== 9'b100010001 || v !== 3'b101) begin
      errors++;
      $display("FAIL bp_release ov=%b ir=%b a=%b v=%b required 0 1 100010001 101", out_valid, in_ready, a_flat, v);
    end
  endtask

  task automatic test_keep();
    beat(1'b0, 1'b1, 0);
    beat(1'b1, 1'b0, 0);
    beat(1'b1, 1'b1, 0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || v !== 3'b110 || a_flat !== 9'b100010001 || mat_ok !== 1'b1) begin
      errors++;
      $display("FAIL keep ov=%b v=%b a=%b mo=%b required 1 110 100010001 1", out_valid, v, a_flat, mat_ok);
    end
    release_out();
  endtask

  task automatic test_gapped();
    // A full frame over a stored matrix must clear mat_ok on its first beat.
    beat(1'b1, 1'b0, 2);
    @(negedge clk);
    checks++;
    if (mat_ok !== 1'b0 || a_flat[0] !== 1'b1) begin
      errors++; $display("FAIL gapped_matok mo=%b a0=%b required 0 1", mat_ok, a_flat[0]);
    end
    for (int k = 1; k < N*N+N; k++)
      beat(k == 4 || k == 8 || k == 9 || k == 11, 1'b0, int'($urandom_range(0, 3)));
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || a_flat !== 9'b100010001 || v !== 3'b101 || mat_ok !== 1'b1) begin
      errors++;
      $display("FAIL gapped ov=%b a=%b v=%b mo=%b required 1 100010001 101 1", out_valid, a_flat, v, mat_ok);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) beat(1'b1, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || a_flat !== 9'b0 || v !== 3'b0 || mat_ok !== 1'b0) begin
      errors++; $display("FAIL reset_mid ov=%b a=%b v=%b mo=%b required 0 0 0 0", out_valid, a_flat, v, mat_ok);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready ir=%b required 1", in_ready); end
    test_full_frame(1'b0);
    release_out();
  endtask

  task automatic test_keep_after_reset();
    logic [N*N+N-1:0] bits;
    bits = {3'b110, 9'b101110011};
    test_reset();
    beat(bits[0], 1'b1, 0);
    @(negedge clk);
    checks++;
    if (a_flat[0] !== 1'b1 || v !== 3'b000) begin
      errors++; $display("FAIL keep_rst_first a0=%b v=%b required 1 000", a_flat[0], v);
    end
    for (int k = 1; k < 3; k++) beat(bits[k], 1'b0, 0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || mat_ok !== 1'b0) begin
      errors++; $display("FAIL keep_rst_early ov=%b mo=%b required 0 0", out_valid, mat_ok);
    end
    for (int k = 3; k < N*N+N; k++) beat(bits[k], 1'b0, 0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || a_flat !== 9'b101110011 || v !== 3'b110 || mat_ok !== 1'b1) begin
      errors++;
      $display("FAIL keep_rst ov=%b a=%b v=%b mo=%b required 1 101110011 110 1", out_valid, a_flat, v, mat_ok);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_full_frame(1'b0);
    test_backpressure();
    test_keep();
    test_gapped();
    test_reset_mid();
    test_keep_after_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
